serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 83 ++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a registered carry, operands
// shifted LSB first, result and carry-out published together with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;

    logic s;
    logic co;

    assign s  = a_sr[0] ^ b_sr[0] ^ c_reg;
    assign co = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_reg) | (b_sr[0] & c_reg);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new request directly so back-to-back adds lose no cycle
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr  <= {s, s_sr[WIDTH-1:1]};
                    c_reg <= co;
                    cnt   <= cnt + 1'b1;
                    // outputs only move here, so partial sums never leak out
                    if (cnt == LAST) begin
                        sum   <= {s, s_sr[WIDTH-1:1]};
                        cout  <= co;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, randomized adds against
// an arithmetic reference, mid-run reset, and an exhaustive sweep of a 2-bit instance.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int checks = 0;
    int errors = 0;

    // model of the last published result (what sum/cout must hold between completions)
    logic [8:0] last_res = 9'd0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete add: checks latency, busy length, stable outputs while running, result.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input string tag);
        logic [8:0] expv;
        int         nbusy;
        bit         seen;
        bit         moved;
        bit         overlap;
        expv = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        nbusy = 0; seen = 0; moved = 0; overlap = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy && done) overlap = 1;
            if (done) begin
                seen = 1;
            end else begin
                if (busy) nbusy++;
                if ({cout, sum} !== last_res) moved = 1;
                @(negedge clk);
            end
        end
        check({tag, "_seen_done"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'd8);
        check({tag, "_hold_while_busy"}, 64'(moved), 64'd0);
        check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, "_result"}, 64'({cout, sum}), 64'(expv));
        last_res = expv;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int         done_at[$];
        logic [8:0] res_at[$];
        int         ndone;
        logic [2:0] e2;
        bit         seen2;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        // reset values
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'({cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            check("idle_result", 64'({cout, sum}), 64'd0);
        end

        // directed cases
        run_add(8'hFF, 8'h01, 1'b0, "ripple");
        run_add(8'hA5, 8'h5A, 1'b1, "cin_a5_5a");
        run_add(8'h12, 8'h34, 1'b0, "plain_12_34");

        // start during RUN must be ignored
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                check("ignore_result", 64'({cout, sum}), 64'h010);
            end
            @(negedge clk);
        end
        check("ignore_done_count", 64'(ndone), 64'd1);
        last_res = 9'h010;

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                done_at.push_back(n);
                res_at.push_back({cout, sum});
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", 64'(done_at.size()), 64'd2);
        if (done_at.size() >= 2) begin
            check("b2b_spacing", 64'(done_at[1] - done_at[0]), 64'd9);
            check("b2b_first", 64'(res_at[0]), 64'h100);
            check("b2b_second", 64'(res_at[1]), 64'h004);
        end
        // let the third accepted add drain
        seen2 = 0;
        for (int i = 0; i < 30 && !seen2; i++) begin
            if (!busy && !done) seen2 = 1; else @(negedge clk);
        end
        check("b2b_drain", 64'(seen2), 64'd1);
        last_res = {cout, sum};

        // randomized adds against the arithmetic model
        for (int k = 0; k < 30; k++)
            run_add(8'($urandom), 8'($urandom), 1'($urandom), "rand");
        run_add(8'hFF, 8'hFF, 1'b1, "max");

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'({cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 9'd0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(ndone), 64'd0);

        // exhaustive sweep on the 2-bit instance
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            e2 = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'd0, v[0]};
            @(negedge clk);
            a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            seen2 = 0;
            for (int j = 0; j < 10 && !seen2; j++) begin
                if (done2) seen2 = 1; else @(negedge clk);
            end
            check("w2_seen_done", 64'(seen2), 64'd1);
            check("w2_result", 64'({cout2, sum2}), 64'(e2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
